// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: load-use bubbles, multi-cycle MDU tracking and
// wrong-path squash on taken branches, driving the PC, IF/ID and ID/EX registers.
module hazard_ctrl #(
    parameter int unsigned LOAD_STALL_CYCLES = 1,
    parameter int unsigned MDU_LATENCY       = 8
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic [4:0] rs_addr,
    input  logic [4:0] rt_addr,
    input  logic       uses_rs,
    input  logic       uses_rt,
    input  logic       uses_hilo,
    input  logic       mdu_start,
    input  logic [4:0] id_rd,
    input  logic       id_is_ram,
    input  logic       id_rf_nwe,
    input  logic       branch_taken,
    output logic       pc_stall,
    output logic       ifid_stall,
    output logic       ifid_flush,
    output logic       id_ex_hazard_mem,
    output logic       mdu_busy,
    output logic       mdu_done
);

    typedef enum logic [1:0] {
        ST_RUN,
        ST_LSTALL,
        ST_MDU
    } state_e;

    localparam logic [3:0] LS_INIT  = (LOAD_STALL_CYCLES > 1) ? 4'(LOAD_STALL_CYCLES - 2) : 4'd0;
    localparam logic [3:0] MDU_INIT = 4'(MDU_LATENCY - 1);

    state_e     state_q, state_d;
    logic [3:0] cnt_q, cnt_d;
    logic       mdu_busy_q, mdu_busy_d;
    logic       mdu_done_q, mdu_done_d;

    logic hit_rs, hit_rt, lu, stall;

    // Register 0 is hardwired, so a load targeting it can never create a dependency.
    assign hit_rs = uses_rs && (rs_addr == id_rd);
    assign hit_rt = uses_rt && (rt_addr == id_rd);
    assign lu     = id_is_ram && id_rf_nwe && (id_rd != 5'd0) && (hit_rs || hit_rt);

    always_comb begin
        stall = 1'b0;
        case (state_q)
            ST_RUN:    stall = lu;
            ST_LSTALL: stall = 1'b1;
            ST_MDU:    stall = uses_hilo || mdu_start || lu;
            default:   stall = 1'b0;
        endcase
    end

    // A taken branch overrides any stall: the wrong-path instructions are squashed instead of held.
    assign pc_stall         = resetn && !branch_taken && stall;
    assign ifid_stall       = resetn && !branch_taken && stall;
    assign ifid_flush       = resetn && branch_taken;
    assign id_ex_hazard_mem = resetn && (branch_taken || stall);
    assign mdu_busy         = mdu_busy_q;
    assign mdu_done         = mdu_done_q;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        mdu_busy_d = mdu_busy_q;
        mdu_done_d = 1'b0;
        case (state_q)
            ST_RUN: begin
                if (!branch_taken) begin
                    if (lu) begin
                        if (LOAD_STALL_CYCLES > 1) begin
                            state_d = ST_LSTALL;
                            cnt_d   = LS_INIT;
                        end
                    end else if (mdu_start) begin
                        state_d    = ST_MDU;
                        cnt_d      = MDU_INIT;
                        mdu_busy_d = 1'b1;
                    end
                end
            end
            ST_LSTALL: begin
                if (branch_taken || cnt_q == 4'd0) begin
                    state_d = ST_RUN;
                    cnt_d   = 4'd0;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            ST_MDU: begin
                // The MDU op predates any branch in EX, so it keeps counting regardless.
                if (cnt_q == 4'd0) begin
                    state_d    = ST_RUN;
                    mdu_busy_d = 1'b0;
                    mdu_done_d = 1'b1;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            default: begin
                state_d    = ST_RUN;
                cnt_d      = 4'd0;
                mdu_busy_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q    <= ST_RUN;
            cnt_q      <= '0;
            mdu_busy_q <= 1'b0;
            mdu_done_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            mdu_busy_q <= mdu_busy_d;
            mdu_done_q <= mdu_done_d;
        end
    end

endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
- Stall/squash controller that drives the ID/EX pipeline register's bubble input (id_ex_hazard_mem) and holds the PC and IF/ID stages.
- Compares the instruction in ID against the one already latched in ID/EX (load-use), tracks a multi-cycle multiply/divide unit (MDU), and squashes wrong-path instructions on taken branches.
- Sits beside the decoder; its outputs are consumed by the PC, IF/ID and ID/EX registers on the next clk edge.

Parameters:
- LOAD_STALL_CYCLES, 1, bubbles inserted per load-use hazard (legal 1..3).
- MDU_LATENCY, 8, cycles the MDU is busy after accepting an op (legal 2..15).

Ports:
- clk  in  1  clock
- resetn  in  1  asynchronous active-low reset
- rs_addr  in  5  rs field of the instruction in ID
- rt_addr  in  5  rt field of the instruction in ID
- uses_rs  in  1  the ID instruction reads rs
- uses_rt  in  1  the ID instruction reads rt
- uses_hilo  in  1  the ID instruction reads HI/LO (mfhi/mflo)
- mdu_start  in  1  the ID instruction is mult/div
- id_rd  in  5  destination register held in ID/EX
- id_is_ram  in  1  ID/EX holds a RAM instruction
- id_rf_nwe  in  1  ID/EX instruction writes the register file (1 = write)
- branch_taken  in  1  EX resolved a taken branch/jump this cycle
- pc_stall  out  1  hold the PC
- ifid_stall  out  1  hold the IF/ID register
- ifid_flush  out  1  clear the IF/ID register
- id_ex_hazard_mem  out  1  load a bubble into ID/EX
- mdu_busy  out  1  the MDU operation is in flight
- mdu_done  out  1  one-cycle pulse when the MDU finishes

Behaviour:
- Reset (async, resetn=0): state RUN, counter 0, mdu_busy=0, mdu_done=0. Combinational outputs evaluate to 0 while in reset. Reset mid-stall or mid-MDU abandons the operation immediately.
- Load-use condition lu = id_is_ram & id_rf_nwe & (id_rd != 0) & ((uses_rs & rs_addr==id_rd) | (uses_rt & rt_addr==id_rd)). Register 0 never causes a hazard.
- Stall outputs are combinational from state and inputs, valid in the same cycle. State, counter and mdu_busy/mdu_done are registered.
- Stall set S: pc_stall=1, ifid_stall=1, id_ex_hazard_mem=1.
- FSM states: RUN, LSTALL, MDU.
- RUN:
  - If lu: assert S. If LOAD_STALL_CYCLES>1, go to LSTALL with cnt=LOAD_STALL_CYCLES-2.
  - Else if mdu_start: no stall; the instruction advances. Go to MDU with cnt=MDU_LATENCY-1 and mdu_busy=1 from the next cycle.
- LSTALL: assert S. If cnt==0, go to RUN; else cnt-1.
- MDU:
  - mdu_busy=1.
  - If uses_hilo or mdu_start, assert S. This is a structural/HI-LO stall; the instruction waits.
  - lu in the MDU state also asserts S for one cycle; the counter keeps running regardless.
  - When cnt==0: go to RUN, mdu_busy=0, and pulse mdu_done=1 on the following cycle.
  - A pending mdu_start is re-evaluated in RUN; this costs one extra cycle.
- branch_taken has highest priority:
  - ifid_flush=1, id_ex_hazard_mem=1, pc_stall=0, ifid_stall=0.
  - LSTALL returns to RUN.
  - MDU keeps counting, because the MDU op is older than the branch.
  - mdu_start and lu in the same cycle are ignored, since that instruction is wrong-path.
- Simultaneous lu and mdu_start in RUN: lu wins; mdu_start is re-sampled after the stall.
- The counter is 4 bits wide and never wraps; decrementing stops at 0.

Test Plan:
- Load-use: ID/EX holds lw with id_is_ram=1, id_rf_nwe=1, id_rd=5; ID has uses_rs=1, rs_addr=5 -> exactly 1 cycle of pc_stall=ifid_stall=id_ex_hazard_mem=1, then all 0.
- No-hazard cases: id_rd=0 with rs_addr=0; or id_is_ram=1 with id_rf_nwe=0 (store) and a matching rt -> all stall outputs 0. Repeat the load-use case with LOAD_STALL_CYCLES=3 -> exactly 3 bubble cycles.
- MDU: mdu_start in RUN (MDU_LATENCY=8), followed by uses_hilo=1 in ID -> mdu_busy=1 for 8 cycles, stall held while busy, mdu_done=1 for 1 cycle, and the stall released in the same cycle mdu_busy drops.
- Branch priority: branch_taken=1 during LSTALL (LOAD_STALL_CYCLES=3, 2nd bubble) -> ifid_flush=1, id_ex_hazard_mem=1, pc_stall=0, and state RUN next cycle. branch_taken during MDU -> mdu_busy still deasserts on schedule.
- Simultaneous lu and mdu_start -> stall first, MDU entered only after the lu clears. Back-to-back mdu_start while in MDU -> stalled until mdu_done + 1.
- Async reset: assert resetn=0 mid-MDU (cnt=4), off the clock edge -> mdu_busy and all stall outputs 0 immediately. After release, RUN with no spurious mdu_done.
